i_cache_nway: RTL

- Parametrised N-way set-associative instruction cache between the fetch stage and the memory read port.
- Successor to the 2-way, one-doubleword-per-line icache.
- Adds configurable ways, sets and multi-beat lines, per-set age-based replacement, and a fence.i flush sequencer.
- Tag/data arrays are synchronous-read memories, so every lookup costs one cycle.

---
 rtl/i_cache_nway_if.sv | 29 ++
 rtl/i_cache_nway.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/i_cache_nway_if.sv
// Fetch-side and refill-side signal bundle for i_cache_nway.
// The slave modport is the cache. The master modport is the core/bus side.
interface i_cache_nway_if #(parameter int ADDR_W = 64);
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_ready;
  logic              core_stall;
  logic              fence_i;
  logic [31:0]       inst_data;
  logic              inst_valid;
  logic              flush_done;
  logic              cache_read_ena;
  logic [ADDR_W-1:0] cache_addr;
  logic              cache_read_resp;
  logic [63:0]       cache_in_data;
  logic              cache_in_valid;
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;

  modport slave (
    input  inst_addr, inst_ready, core_stall, fence_i, cache_in_data, cache_in_valid,
    output inst_data, inst_valid, flush_done, cache_read_ena, cache_addr,
           cache_read_resp, hit_cnt, miss_cnt
  );
  modport master (
    output inst_addr, inst_ready, core_stall, fence_i, cache_in_data, cache_in_valid,
    input  inst_data, inst_valid, flush_done, cache_read_ena, cache_addr,
           cache_read_resp, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/i_cache_nway.sv
// N-way set-associative instruction cache with age-based replacement and fence.i flush.
// Define ICACHE_PERF_CNT_EN to build the hit/miss counters; otherwise they read as 0.
module i_cache_nway #(
  parameter int ADDR_W     = 64,
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_BEATS = 4,
  parameter int AGE_W      = 3
)(
  input logic         clk,
  input logic         rst,
  i_cache_nway_if.slave bus
);
  localparam int IW = $clog2(SETS);
  localparam int BW = $clog2(LINE_BEATS);
  localparam int OW = BW + 3;
  localparam int TW = ADDR_W - OW - IW;
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int DW = IW + BW;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef enum logic [2:0] {IDLE, LOOKUP, RESP, REFILL, FLUSH, FDONE} state_t;
  state_t state, state_nx;

  logic [ADDR_W-1:0] req_addr;
  logic [TW-1:0]     req_tag;
  logic [IW-1:0]     req_idx;
  logic [DW-1:0]     rd_daddr;
  logic [SETS-1:0][WAYS-1:0]            valid;
  logic [SETS-1:0][WAYS-1:0][AGE_W-1:0] age;
  logic [WAYS-1:0][TW-1:0] rd_tag;
  logic [WAYS-1:0][63:0]   rd_data;
  logic [BW-1:0]     beat_cnt;
  logic [WW-1:0]     way_q, hit_way, victim_nx;
  logic [AGE_W-1:0]  best;
  logic [IW-1:0]     flush_idx;
  logic [31:0]       resp_word;
  logic hit, found, retry, fence_pend, rd_en, fill_we, fill_last, resp_ok, touch;

  assign req_tag   = req_addr[ADDR_W-1:OW+IW];
  assign req_idx   = req_addr[OW+IW-1:OW];
  assign fill_we   = (state == REFILL) && bus.cache_in_valid;
  assign fill_last = (beat_cnt == BW'(LINE_BEATS-1));
  assign resp_ok   = (state == RESP) && !bus.core_stall;
  assign touch     = resp_ok || (fill_we && fill_last);
  assign rd_en     = (state_nx == LOOKUP);
  assign rd_daddr  = (state == IDLE) ? bus.inst_addr[OW+IW-1:3] : req_addr[OW+IW-1:3];

  // Write-first sync-read arrays, so the post-refill lookup sees the beat/tag landing now.
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [TW-1:0] tag_mem  [SETS];
    logic [63:0]   data_mem [SETS*LINE_BEATS];
    logic [TW-1:0] q_tag;
    logic [63:0]   q_data;
    logic          data_we, tag_we;
    logic [DW-1:0] waddr;
    assign data_we = fill_we && (way_q == WW'(w));
    assign tag_we  = data_we && fill_last;
    assign waddr   = {req_idx, beat_cnt};
    always_ff @(posedge clk) begin
      if (data_we) data_mem[waddr] <= bus.cache_in_data;
      if (tag_we)  tag_mem[req_idx] <= req_tag;
      if (rd_en) begin
        q_data <= (data_we && waddr == rd_daddr) ? bus.cache_in_data : data_mem[rd_daddr];
        q_tag  <= (tag_we && req_idx == rd_daddr[DW-1:BW]) ? req_tag : tag_mem[rd_daddr[DW-1:BW]];
      end
    end
    assign rd_tag[w]  = q_tag;
    assign rd_data[w] = q_data;
  end

  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid[req_idx][w] && rd_tag[w] == req_tag) begin
        hit = 1'b1;
        hit_way = WW'(w);
      end
    found = 1'b0;
    victim_nx = '0;
    best = '0;
    for (int w = 0; w < WAYS; w++)
      if (!found && !valid[req_idx][w]) begin
        found = 1'b1;
        victim_nx = WW'(w);
      end
    if (!found) begin
      best = age[req_idx][0];
      for (int w = 1; w < WAYS; w++)
        if (age[req_idx][w] > best) begin
          best = age[req_idx][w];
          victim_nx = WW'(w);
        end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.fence_i || fence_pend) state_nx = FLUSH;
               else if (bus.inst_ready)       state_nx = LOOKUP;
      LOOKUP:  state_nx = hit ? RESP : REFILL;
      RESP:    state_nx = IDLE;
      REFILL:  if (fill_we && fill_last) state_nx = LOOKUP;
      FLUSH:   if (flush_idx == IW'(SETS-1)) state_nx = FDONE;
      FDONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      valid <= '0;
      age <= '0;
      req_addr <= '0;
      beat_cnt <= '0;
      way_q <= '0;
      retry <= 1'b0;
      fence_pend <= 1'b0;
      resp_word <= '0;
      flush_idx <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx == LOOKUP) begin
        req_addr <= bus.inst_addr;
        retry <= 1'b0;
      end
      if (state == IDLE) begin
        if (state_nx == FLUSH) fence_pend <= 1'b0;
      end else if (bus.fence_i && state != FLUSH && state != FDONE)
        fence_pend <= 1'b1;
      if (state == LOOKUP) begin
        resp_word <= req_addr[2] ? rd_data[hit_way][63:32] : rd_data[hit_way][31:0];
        way_q <= hit ? hit_way : victim_nx;
      end
      if (fill_we) beat_cnt <= beat_cnt + BW'(1);
      if (fill_we && fill_last) begin
        valid[req_idx][way_q] <= 1'b1;
        retry <= 1'b1;
      end
      if (touch)
        for (int w = 0; w < WAYS; w++)
          if (way_q == WW'(w)) age[req_idx][w] <= '0;
          else if (valid[req_idx][w] && age[req_idx][w] != AGE_MAX)
            age[req_idx][w] <= age[req_idx][w] + AGE_W'(1);
      if (state == FLUSH) begin
        valid[flush_idx] <= '0;
        age[flush_idx] <= '0;
        flush_idx <= flush_idx + IW'(1);
      end
    end
  end

  assign bus.inst_valid      = resp_ok;
  assign bus.inst_data       = resp_ok ? resp_word : 32'd0;
  assign bus.flush_done      = (state == FDONE);
  assign bus.cache_read_ena  = (state == REFILL);
  assign bus.cache_addr      = (state == REFILL) ? {req_tag, req_idx, beat_cnt, 3'b000} : '0;
  assign bus.cache_read_resp = fill_we;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_q, miss_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q <= '0;
      miss_q <= '0;
    end else begin
      if (state == LOOKUP && !hit) miss_q <= miss_q + 32'd1;
      if (resp_ok && !retry)       hit_q <= hit_q + 32'd1;
    end
  end
  assign bus.hit_cnt  = hit_q;
  assign bus.miss_cnt = miss_q;
  logic unused_ok;
  assign unused_ok = ^req_addr[1:0];
`else
  assign bus.hit_cnt  = 32'd0;
  assign bus.miss_cnt = 32'd0;
  logic unused_ok;
  assign unused_ok = ^{req_addr[1:0], retry};
`endif
endmodule
